// File: rtl/gauss_poly_seq_if.sv
// Signal bundle between the Gaussian polynomial sequencer, its RNG source,
// the Gaussian sampler and the coefficient memory.
interface gauss_poly_seq_if #(
    parameter int AW = 10
);
    logic               start;
    logic               rng_req;
    logic               rng_valid;
    logic [127:0]       rng;
    logic               g_ena;
    logic               g_rng_valid;
    logic [127:0]       g_rng;
    logic               g_extract;
    logic               g_val_valid;
    logic signed [31:0] g_val;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic signed [7:0]  wr_data;
    logic               busy;
    logic               done;
    logic               range_err;
    logic               tmo_err;
    logic [31:0]        norm_sq;

    // Sequencer side.
    modport master (
        input  start, rng_valid, rng, g_val_valid, g_val,
        output rng_req, g_ena, g_rng_valid, g_rng, g_extract,
               wr_en, wr_addr, wr_data, busy, done, range_err, tmo_err, norm_sq
    );

    // Environment side (RNG, sampler, memory, controller).
    modport slave (
        output start, rng_valid, rng, g_val_valid, g_val,
        input  rng_req, g_ena, g_rng_valid, g_rng, g_extract,
               wr_en, wr_addr, wr_data, busy, done, range_err, tmo_err, norm_sq
    );
endinterface

// File: rtl/gauss_poly_seq.sv
// Gaussian polynomial sequencer: pulls one RNG word per coefficient, hands it
// to the sampler, stores the clamped result for f (0..N-1) then g (N..2N-1)
// and accumulates the saturating squared norm of the raw samples.
module gauss_poly_seq #(
    parameter int N   = 512,
    parameter int AW  = 10,
    parameter int TMO = 255
) (
    input  logic clk,
    input  logic rst_n,
    gauss_poly_seq_if.master bus
);

    localparam int TW = (TMO < 2) ? 1 : $clog2(TMO + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(2 * N - 1);
    localparam logic signed [31:0] VMAX = 32'sd127;
    localparam logic signed [31:0] VMIN = -32'sd127;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_FEED,
        ST_WAIT,
        ST_STORE,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic [TW-1:0]      wait_q, wait_d;
    logic [127:0]       g_rng_q, g_rng_d;
    logic signed [31:0] val_q, val_d;
    logic [31:0]        norm_q, norm_d;
    logic               range_err_q, range_err_d;
    logic               tmo_err_q, tmo_err_d;

    logic               out_of_range;
    logic signed [7:0]  clamped;
    logic [63:0]        val_ext;
    logic [63:0]        val_sq;
    logic [64:0]        norm_sum;
    logic [31:0]        norm_sat;

    // Clamp, range flag and saturating norm update for the captured sample.
    always_comb begin
        out_of_range = (val_q > VMAX) || (val_q < VMIN);
        if (val_q > VMAX) begin
            clamped = 8'sd127;
        end else if (val_q < VMIN) begin
            clamped = -8'sd127;
        end else begin
            clamped = val_q[7:0];
        end
        // Low 64 bits of the unsigned product of the sign-extended operands
        // equal the signed square, which is always non-negative and < 2^63.
        val_ext  = {{32{val_q[31]}}, val_q};
        val_sq   = val_ext * val_ext;
        norm_sum = {33'b0, norm_q} + {1'b0, val_sq};
        norm_sat = (|norm_sum[64:32]) ? '1 : norm_sum[31:0];
    end

    // Next-state and datapath update for the run sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        g_rng_d     = g_rng_q;
        val_d       = val_q;
        norm_d      = norm_q;
        range_err_d = range_err_q;
        tmo_err_d   = tmo_err_q;

        unique case (state_q)
            ST_IDLE, ST_ERR: begin
                if (bus.start) begin
                    cnt_d       = '0;
                    norm_d      = '0;
                    range_err_d = 1'b0;
                    tmo_err_d   = 1'b0;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.rng_valid) begin
                    g_rng_d = bus.rng;
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                wait_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.g_val_valid) begin
                    val_d   = bus.g_val;
                    state_d = ST_STORE;
                end else if (wait_q == TW'(TMO)) begin
                    tmo_err_d = 1'b1;
                    state_d   = ST_ERR;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            ST_STORE: begin
                norm_d = norm_sat;
                if (out_of_range) begin
                    range_err_d = 1'b1;
                end
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + AW'(1);
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wait_q      <= '0;
            g_rng_q     <= '0;
            val_q       <= '0;
            norm_q      <= '0;
            range_err_q <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            g_rng_q     <= g_rng_d;
            val_q       <= val_d;
            norm_q      <= norm_d;
            range_err_q <= range_err_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        bus.rng_req     = (state_q == ST_REQ);
        bus.g_ena       = (state_q == ST_REQ) || (state_q == ST_FEED) ||
                          (state_q == ST_WAIT) || (state_q == ST_STORE);
        bus.g_rng_valid = (state_q == ST_FEED);
        bus.g_rng       = g_rng_q;
        bus.g_extract   = (state_q == ST_STORE);
        bus.wr_en       = (state_q == ST_STORE);
        bus.wr_addr     = (state_q == ST_STORE) ? cnt_q : '0;
        bus.wr_data     = (state_q == ST_STORE) ? clamped : '0;
        bus.busy        = (state_q != ST_IDLE) && (state_q != ST_ERR);
        bus.done        = (state_q == ST_DONE);
        bus.range_err   = range_err_q;
        bus.tmo_err     = tmo_err_q;
        bus.norm_sq     = norm_q;
    end

endmodule

// File: doc/gauss_poly_seq.md
GAUSS_POLY_SEQ -- requirements
Module: gauss_poly_seq

Interface
REQ-001 SHALL provide parameter N, default 512: coefficients per polynomial; the block fills f and then g, 2N samples total.
REQ-002 SHALL provide parameter AW, default 10: write-address width, with 2^AW >= 2N.
REQ-003 SHALL provide parameter TMO, default 255: maximum number of WAIT cycles before a timeout error.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-high reset (1 = reset); the name follows the codebase port convention.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle pulse that begins a run.
REQ-007 SHALL have port rng_req, output, 1 bit: request for one 128-bit random word from the upstream RNG.
REQ-008 SHALL have port rng_valid, input, 1 bit: the upstream word is valid this cycle.
REQ-009 SHALL have port rng, input, 128 bits: the upstream random word.
REQ-010 SHALL have port g_ena, output, 1 bit: sampler enable, high from start until DONE or ERR.
REQ-011 SHALL have port g_rng_valid, output, 1 bit: one-cycle strobe that feeds a word to the sampler.
REQ-012 SHALL have port g_rng, output, 128 bits: the word fed to the sampler.
REQ-013 SHALL have port g_extract, output, 1 bit: one-cycle acknowledge that the sample has been consumed.
REQ-014 SHALL have port g_val_valid, input, 1 bit: the sampler result is ready.
REQ-015 SHALL have port g_val, input, signed 32 bits: the sampler result.
REQ-016 SHALL have port wr_en, output, 1 bit: coefficient memory write strobe.
REQ-017 SHALL have port wr_addr, output, AW bits: write address; 0..N-1 is f, N..2N-1 is g.
REQ-018 SHALL have port wr_data, output, signed 8 bits: the coefficient, saturated to [-127, 127].
REQ-019 SHALL have ports busy, done, range_err, tmo_err (outputs, 1 bit each) and norm_sq (output, 32 bits).

Function
REQ-020 SHALL implement the FSM states IDLE, REQ, FEED, WAIT, STORE, DONE and ERR.
REQ-021 SHALL, in IDLE, on start=1, clear the sample counter, norm_sq, range_err and tmo_err, and go to REQ on the next cycle.
REQ-022 SHALL, in REQ, hold rng_req=1; on rng_valid=1, latch rng into g_rng and go to FEED; rng_valid in any other state SHALL be ignored.
REQ-023 SHALL, in FEED, drive g_rng_valid=1 for exactly one cycle with g_rng stable, then go to WAIT.
REQ-024 SHALL, in WAIT, count cycles; on g_val_valid=1, capture g_val and go to STORE.
REQ-025 SHALL, in WAIT, go to ERR when the cycle count reaches TMO without g_val_valid, and set tmo_err.
REQ-026 SHALL, in STORE, assert wr_en=1 and g_extract=1 together for one cycle, with wr_addr equal to the sample counter.
REQ-027 SHALL, in STORE, set wr_data to g_val clamped to [-127, 127], and set range_err (sticky) if |g_val| > 127.
REQ-028 SHALL, in STORE, add g_val*g_val (full 64-bit product) to norm_sq, saturating at 0xFFFFFFFF.
REQ-029 SHALL, after STORE, increment the counter and go to REQ if the counter is below 2N-1, otherwise to DONE.
REQ-030 SHALL, in DONE, pulse done=1 for one cycle, drop g_ena, hold norm_sq, range_err and tmo_err until the next start, and return to IDLE.
REQ-031 SHALL, in ERR, drop g_ena and all strobes and remain until start (which restarts as from IDLE) or reset.
REQ-032 SHALL hold busy=1 in every state except IDLE and ERR.
REQ-033 SHALL ignore start while busy=1.
REQ-034 SHALL ignore g_val_valid outside WAIT, with no write and no extract.
REQ-035 SHALL have a minimum per-sample latency of 4 cycles (REQ, FEED, WAIT, STORE) with zero wait states.

Reset
REQ-036 SHALL, while rst_n=1 at a clock edge, enter IDLE and drive every output to 0, including g_rng, wr_addr, wr_data and norm_sq.
REQ-037 SHALL, on reset mid-run, abandon the run with no done pulse and no further writes, and require a fresh start afterwards.

Verification
REQ-038 SHALL pass: N=4, a zero-wait RNG, and the sampler returning 3, -2, 0, 1, 5, -1, 2, 0 -> wr_addr 0..7 with matching wr_data, norm_sq=44, done once, range_err=0.
REQ-039 SHALL pass: a sample of -300 at address 2 -> wr_data=-127, range_err=1, norm_sq including 90000, and the run completing normally.
REQ-040 SHALL pass: the sampler silent for 256 cycles after FEED (TMO=255) -> tmo_err=1, state ERR, g_ena=0, and no further wr_en.
REQ-041 SHALL pass: reset asserted after the 3rd write -> all outputs 0 next cycle, no done pulse, and a fresh start producing the full 8 writes from address 0.
REQ-042 SHALL pass: start pulsed mid-run and g_val_valid pulsed during REQ -> no restart, no extra write, and a sample count exactly 2N.
REQ-043 SHALL pass: samples of 65535 repeated -> norm_sq saturating at 0xFFFFFFFF.
